// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [BCD_DIGIT_W-1:0] BCD_ADJUST    = 4'd6;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } bcd_state_e;

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder: binary add, then +6 correction when the sum exceeds 9.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a,
  input  logic [BCD_DIGIT_W-1:0] b,
  input  logic                   ci,
  output logic [BCD_DIGIT_W-1:0] s,
  output logic                   co
);

  logic [BCD_DIGIT_W:0] t;

  always_comb begin
    t = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, ci};
    if (t > {1'b0, BCD_MAX_DIGIT}) begin
      // Only the low nibble matters: (t + 6) mod 16.
      s  = t[BCD_DIGIT_W-1:0] + BCD_ADJUST;
      co = 1'b1;
    end else begin
      s  = t[BCD_DIGIT_W-1:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder, one digit per cycle, LSD first, valid/ready on both sides.
// Define BCD_SERIAL_CHECK_EN to flag operand digits greater than 9 on err.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
  input  logic                          cin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
  output logic                          cout,
  output logic                          err
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  bcd_state_e state_q, state_d;

  logic [DIGITS-1:0][BCD_DIGIT_W-1:0] a_q, a_d;
  logic [DIGITS-1:0][BCD_DIGIT_W-1:0] b_q, b_d;
  logic [DIGITS-1:0][BCD_DIGIT_W-1:0] sum_q, sum_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic                               carry_q, carry_d;
  logic                               cout_q, cout_d;

  bcd_digit_t dig_s;
  logic       dig_co;
  logic       last_digit;

  bcd_digit_add u_digit (
    .a  (a_q[idx_q]),
    .b  (b_q[idx_q]),
    .ci (carry_q),
    .s  (dig_s),
    .co (dig_co)
  );

  assign last_digit = (state_q == ADD) && (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[idx_q] = dig_s;
        carry_d      = dig_co;
        idx_d        = idx_q + IDX_W'(1);
        if (last_digit) begin
          cout_d  = dig_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

`ifdef BCD_SERIAL_CHECK_EN
  logic              err_q, err_d;
  logic [DIGITS-1:0] bad_a, bad_b;

  for (genvar g = 0; g < DIGITS; g++) begin : g_chk
    assign bad_a[g] = (a_q[g] > BCD_MAX_DIGIT);
    assign bad_b[g] = (b_q[g] > BCD_MAX_DIGIT);
  end

  // Latched together with cout so err is stable for the whole DONE phase.
  always_comb begin
    err_d = err_q;
    if (last_digit) begin
      err_d = |{bad_a, bad_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder (DIGITS=4): decimal reference model, decoupled monitor.
module tb_bcd_serial_adder;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    time          acc_t;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err       (err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Decimal arithmetic on digit values; digits above 9 are weighted as-is.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c);
    exp_t e;
    longint unsigned tot, lim;
    logic [3:0] da, db;
    bit bad;
    tot = longint'(c);
    lim = 1;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      da  = av[i*4 +: 4];
      db  = bv[i*4 +: 4];
      tot += (longint'(da) + longint'(db)) * lim;
      if (da > 9 || db > 9) bad = 1'b1;
      lim *= 10;
    end
    e.cout = (tot >= lim);
    tot    = tot % lim;
    e.sum  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      e.sum[i*4 +: 4] = 4'(tot % 10);
      tot /= 10;
    end
`ifdef BCD_SERIAL_CHECK_EN
    e.err = bad;
`else
    e.err = 1'b0;
`endif
    e.acc_t = 0;
    return e;
  endfunction

  // Monitor: pop on each new result, then require stability while it is held.
  bit   pv = 1'b0;
  exp_t held;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!pv) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          held = sb.pop_front();
          chk("sum", 64'(sum), 64'(held.sum));
          chk("cout", 64'(cout), 64'(held.cout));
          chk("err", 64'(err), 64'(held.err));
          chk("latency_cycles", 64'(($time - held.acc_t - 5) / 10 + 1), 64'(DIGITS + 1));
        end
      end else begin
        chk("stable_sum", 64'(sum), 64'(held.sum));
        chk("stable_cout", 64'(cout), 64'(held.cout));
        chk("stable_err", 64'(err), 64'(held.err));
      end
    end
    pv = rst_n && out_valid;
  end

  always @(negedge clk) begin
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Returns at the falling edge inside the second ADD cycle.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c,
                       input bit expect_out);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail_now("in_ready_timeout");
      return;
    end
    a        = av;
    b        = bv;
    cin      = c;
    in_valid = 1'b1;
    @(posedge clk);
    if (expect_out) begin
      e       = model(av, bv, c);
      e.acc_t = $time;
      sb.push_back(e);
    end
    @(negedge clk);
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || !in_ready) fail_now("drain_timeout");
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    issue(16'h1234, 16'h5678, 1'b0, 1'b1);
    issue(16'h9999, 16'h0001, 1'b0, 1'b1);
    issue(16'h9999, 16'h9999, 1'b1, 1'b1);
    issue(16'h0000, 16'h0000, 1'b1, 1'b1);
    drain();

    // Back-pressure: hold the result for 5 cycles.
    out_ready = 1'b0;
    issue(16'h2468, 16'h1357, 1'b1, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail_now("stall_valid_timeout");
    repeat (5) begin
      @(negedge clk);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", 64'(out_valid), 64'd0);
    chk("release_in_ready", 64'(in_ready), 64'd1);

    // Reset during the second ADD cycle aborts the operation.
    issue(16'h0123, 16'h0456, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    repeat (8) begin
      @(negedge clk);
      chk("abort_no_valid", 64'(out_valid), 64'd0);
    end
    issue(16'h0005, 16'h0005, 1'b0, 1'b1);
    drain();

    // Invalid digit operand.
    issue(16'h00A0, 16'h0000, 1'b0, 1'b1);
    drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), 1'b1);
    end
    drain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
